// File: rtl/pong_sfx.sv
// pong_sfx: prioritized hit/score/win tone generator producing a square wave and a signed PCM sample.
// Define SFX_VOLUME_EN to add a 2-bit volume input that scales the PCM sample.
module pong_sfx #(
    parameter int HIT_HALF = 56818,
    parameter int HIT_LEN = 2500000,
    parameter int SCORE_HALF = 113636,
    parameter int SCORE_LEN = 12500000,
    parameter int WIN_HALF = 28409,
    parameter int WIN_LEN = 5000000,
    parameter int GAP_LEN = 2500000,
    parameter logic signed [15:0] AMPLITUDE = 16'sd8000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               collision,
    input  logic [3:0]         p1_score,
    input  logic [3:0]         p2_score,
    input  logic [1:0]         winner,
`ifdef SFX_VOLUME_EN
    input  logic [1:0]         volume,
`endif
    output logic               tone_out,
    output logic signed [15:0] sample,
    output logic [1:0]         sfx_id,
    output logic               busy
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PW = $clog2(max2(max2(HIT_HALF, SCORE_HALF), WIN_HALF) + 1);
    localparam int CW = $clog2(max2(max2(HIT_LEN, SCORE_LEN), max2(WIN_LEN, GAP_LEN)) + 1);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           beeps_q, beeps_d;
    logic [1:0]           id_q, id_d;
    logic                 tone_q, tone_d;
    logic signed [15:0]   sample_q, sample_d;
    logic                 hist_vld_q, collision_q;
    logic [3:0]           p1_q, p2_q;
    logic [1:0]           winner_q;
    logic                 hit_evt, score_evt, win_evt;
    logic [1:0]           evt_id;
    logic signed [15:0]   amp;
    int                   half_sel, len_sel;

    // History is invalid until the first edge after reset so held inputs cannot fire events.
    assign hit_evt   = hist_vld_q & collision & ~collision_q;
    assign score_evt = hist_vld_q & (({1'b0, p1_score} == {1'b0, p1_q} + 5'd1) |
                                     ({1'b0, p2_score} == {1'b0, p2_q} + 5'd1));
    assign win_evt   = hist_vld_q & (winner != 2'd0) & (winner_q == 2'd0);
    assign evt_id    = win_evt ? 2'd3 : score_evt ? 2'd2 : hit_evt ? 2'd1 : 2'd0;

    assign half_sel = (id_q == 2'd3) ? WIN_HALF : (id_q == 2'd2) ? SCORE_HALF : HIT_HALF;
    assign len_sel  = (id_q == 2'd3) ? WIN_LEN : (id_q == 2'd2) ? SCORE_LEN : HIT_LEN;

`ifdef SFX_VOLUME_EN
    assign amp = (volume == 2'd0) ? 16'sd0 : AMPLITUDE >>> (2'd3 - volume);
`else
    assign amp = AMPLITUDE;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        beeps_d = beeps_q;
        id_d    = id_q;
        tone_d  = tone_q;
        case (state_q)
            TONE: begin
                if (int'(cnt_q) == len_sel - 1) begin
                    phase_d = '0;
                    cnt_d   = '0;
                    tone_d  = 1'b0;
                    state_d = (beeps_q > 2'd1) ? GAP : IDLE;
                    beeps_d = (beeps_q > 2'd1) ? beeps_q - 2'd1 : beeps_q;
                    id_d    = (beeps_q > 2'd1) ? id_q : 2'd0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    phase_d = (int'(phase_q) == half_sel - 1) ? '0 : phase_q + PW'(1);
                    tone_d  = (int'(phase_q) == half_sel - 1) ? ~tone_q : tone_q;
                end
            end
            GAP: begin
                if (int'(cnt_q) == GAP_LEN - 1) begin
                    state_d = TONE;
                    cnt_d   = '0;
                    phase_d = '0;
                    tone_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
        if (evt_id > id_q) begin
            state_d = TONE;
            id_d    = evt_id;
            cnt_d   = '0;
            phase_d = '0;
            tone_d  = 1'b1;
            beeps_d = (evt_id == 2'd3) ? 2'd3 : 2'd1;
        end
        sample_d = (state_d != TONE) ? 16'sd0 : tone_d ? amp : -amp;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            cnt_q       <= '0;
            beeps_q     <= '0;
            id_q        <= '0;
            tone_q      <= 1'b0;
            sample_q    <= '0;
            hist_vld_q  <= 1'b0;
            collision_q <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            winner_q    <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            beeps_q     <= beeps_d;
            id_q        <= id_d;
            tone_q      <= tone_d;
            sample_q    <= sample_d;
            hist_vld_q  <= 1'b1;
            collision_q <= collision;
            p1_q        <= p1_score;
            p2_q        <= p2_score;
            winner_q    <= winner;
        end
    end

    assign tone_out = tone_q;
    assign sample   = sample_q;
    assign sfx_id   = id_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_pong_sfx.sv
// tb_pong_sfx: table vectors, hand sequences and a randomized timeline model for pong_sfx.
module tb_pong_sfx;
    localparam int GAP = 3;
    localparam logic signed [15:0] AMP = 16'sd100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic collision = 1'b0;
    logic [3:0] p1_score = 4'd0, p2_score = 4'd0;
    logic [1:0] winner = 2'd0;
    logic [1:0] vol = 2'd3;
    logic tone_out;
    logic signed [15:0] sample;
    logic [1:0] sfx_id;
    logic busy;
    int tests = 0, fails = 0;

    pong_sfx #(
        .HIT_HALF(2), .HIT_LEN(8), .SCORE_HALF(4), .SCORE_LEN(16),
        .WIN_HALF(1), .WIN_LEN(4), .GAP_LEN(GAP), .AMPLITUDE(AMP)
    ) dut (
        .clk(clk), .reset(reset), .collision(collision),
        .p1_score(p1_score), .p2_score(p2_score), .winner(winner),
`ifdef SFX_VOLUME_EN
        .volume(vol),
`endif
        .tone_out(tone_out), .sample(sample), .sfx_id(sfx_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic c; logic [3:0] p1; logic [3:0] p2; logic [1:0] w;
        logic t; logic [1:0] id; int s;
    } vec_t;
    vec_t tbl[30];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic t, input int s, input logic [1:0] id, input logic b);
        tests++;
        if (tone_out !== t || sample !== 16'(s) || sfx_id !== id || busy !== b) begin
            fails++;
            $display("FAIL %s: got tone=%0b sample=%0d id=%0d busy=%0b, want tone=%0b sample=%0d id=%0d busy=%0b",
                     nm, tone_out, sample, sfx_id, busy, t, s, id, b);
        end
    endtask

    function automatic int amp_of(input logic [1:0] v);
`ifdef SFX_VOLUME_EN
        return (v == 2'd0) ? 0 : int'(AMP) / (1 << (3 - int'(v)));
`else
        return int'(AMP);
`endif
    endfunction

    function automatic int hlf(input int id); return id == 3 ? 1 : id == 2 ? 4 : 2; endfunction
    function automatic int ln(input int id);  return id == 3 ? 4 : id == 2 ? 16 : 8; endfunction
    function automatic int bp(input int id);  return id == 3 ? 3 : 1; endfunction

    // Reference model: an effect is a start time plus an id; outputs follow from elapsed cycles.
    int m_id, m_k;
    bit m_prim;
    logic m_col;
    logic [3:0] m_p1, m_p2;
    logic [1:0] m_w;

    task automatic model_edge();
        int ev, cur;
        cur = m_id;
        if (m_id != 0) begin
            m_k++;
            if (m_k >= bp(m_id) * ln(m_id) + (bp(m_id) - 1) * GAP) m_id = 0;
        end
        ev = 0;
        if (m_prim) begin
            if (winner != 0 && m_w == 0) ev = 3;
            else if (int'(p1_score) == int'(m_p1) + 1 || int'(p2_score) == int'(m_p2) + 1) ev = 2;
            else if (collision && !m_col) ev = 1;
        end
        if (ev > cur) begin
            m_id = ev;
            m_k = 0;
        end
        m_prim = 1;
        m_col = collision;
        m_p1 = p1_score;
        m_p2 = p2_score;
        m_w = winner;
    endtask

    task automatic model_check();
        logic t;
        int s, r;
        t = 1'b0;
        s = 0;
        if (m_id != 0) begin
            r = m_k % (ln(m_id) + GAP);
            if (r < ln(m_id)) begin
                t = ((r / hlf(m_id)) % 2) == 0;
                s = t ? amp_of(vol) : -amp_of(vol);
            end
        end
        chk("random", t, s, 2'(m_id), m_id != 0);
    endtask

    initial begin
        int pat[7];
        pat = '{1, -1, 1, -1, 0, 0, 0};
        tbl[0]  = '{1, 3, 9, 0, 1, 1, 100};
        tbl[1]  = '{1, 3, 9, 0, 1, 1, 100};
        tbl[2]  = '{1, 3, 9, 0, 0, 1, -100};
        tbl[3]  = '{1, 3, 9, 0, 0, 1, -100};
        tbl[4]  = '{1, 3, 9, 0, 1, 1, 100};
        tbl[5]  = '{0, 3, 9, 0, 1, 1, 100};
        tbl[6]  = '{0, 3, 9, 0, 0, 1, -100};
        tbl[7]  = '{0, 3, 9, 0, 0, 1, -100};
        tbl[8]  = '{0, 3, 9, 0, 0, 0, 0};
        tbl[9]  = '{1, 3, 9, 0, 1, 1, 100};
        tbl[10] = '{1, 4, 9, 0, 1, 2, 100};
        tbl[11] = '{0, 4, 9, 0, 1, 2, 100};
        tbl[12] = '{0, 4, 9, 0, 1, 2, 100};
        tbl[13] = '{0, 4, 9, 0, 1, 2, 100};
        tbl[14] = '{0, 4, 9, 0, 0, 2, -100};
        tbl[15] = '{1, 4, 9, 0, 0, 2, -100};
        tbl[16] = '{1, 4, 9, 0, 0, 2, -100};
        tbl[17] = '{0, 4, 9, 0, 0, 2, -100};
        tbl[18] = '{0, 4, 9, 0, 1, 2, 100};
        tbl[19] = '{0, 4, 9, 0, 1, 2, 100};
        tbl[20] = '{0, 4, 9, 0, 1, 2, 100};
        tbl[21] = '{0, 4, 9, 0, 1, 2, 100};
        tbl[22] = '{0, 4, 9, 0, 0, 2, -100};
        tbl[23] = '{0, 4, 9, 0, 0, 2, -100};
        tbl[24] = '{0, 4, 9, 0, 0, 2, -100};
        tbl[25] = '{0, 4, 9, 0, 0, 2, -100};
        tbl[26] = '{0, 4, 9, 0, 0, 0, 0};
        tbl[27] = '{0, 7, 5, 0, 0, 0, 0};
        tbl[28] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[29] = '{0, 0, 0, 0, 0, 0, 0};

        tick();
        chk("reset_state", 0, 0, 0, 0);
        tick();
        p1_score = 4'd3;
        p2_score = 4'd9;
        reset = 1'b1;
        tick();
        chk("prime_idle", 0, 0, 0, 0);

        foreach (tbl[i]) begin
            collision = tbl[i].c;
            p1_score = tbl[i].p1;
            p2_score = tbl[i].p2;
            winner = tbl[i].w;
            tick();
            chk($sformatf("vec%0d", i), tbl[i].t, tbl[i].s, tbl[i].id, tbl[i].id != 0);
        end

        p2_score = 4'd9;
        tick();
        chk("pre_win_idle", 0, 0, 0, 0);
        winner = 2'd1;
        p2_score = 4'd10;
        for (int k = 0; k < 18; k++) begin
            tick();
            chk($sformatf("win_k%0d", k), pat[k % 7] > 0, pat[k % 7] * 100, 3, 1);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("win_no_score", 0, 0, 0, 0);
        end

        winner = 2'd0;
        tick();
        chk("winner_fall", 0, 0, 0, 0);
        winner = 2'd2;
        tick();
        chk("win2_start", 1, 100, 3, 1);
        for (int k = 0; k < 3; k++) tick();
        collision = 1'b1;
        #2 reset = 1'b0;
        #1 chk("async_reset", 0, 0, 0, 0);
        tick();
        chk("held_reset", 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk("release_prime", 0, 0, 0, 0);
        tick();
        chk("held_collision", 0, 0, 0, 0);
        collision = 1'b0;
        tick();
        chk("collision_fall", 0, 0, 0, 0);
        collision = 1'b1;
        tick();
        chk("rehit", 1, 100, 1, 1);
`ifdef SFX_VOLUME_EN
        vol = 2'd1;
        tick();
        chk("vol1_hi", 1, 25, 1, 1);
        tick();
        chk("vol1_lo", 0, -25, 1, 1);
        vol = 2'd0;
        tick();
        chk("vol0_lo", 0, 0, 1, 1);
        tick();
        chk("vol0_hi", 1, 0, 1, 1);
        vol = 2'd3;
`endif

        reset = 1'b0;
        collision = 1'b0;
        winner = 2'd0;
        p1_score = 4'd0;
        p2_score = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        m_prim = 0;
        m_id = 0;
        m_k = 0;
        for (int i = 0; i < 1500; i++) begin
            tick();
            model_edge();
            model_check();
            if ($urandom_range(0, 3) == 0) collision = ~collision;
            case ($urandom_range(0, 19))
                0: p1_score = (p1_score >= 4'd10) ? 4'd0 : p1_score + 4'd1;
                1: p2_score = (p2_score >= 4'd10) ? 4'd0 : p2_score + 4'd1;
                2: begin p1_score = 4'd0; p2_score = 4'd0; end
                3: winner = 2'($urandom_range(0, 2));
                default: ;
            endcase
`ifdef SFX_VOLUME_EN
            if ($urandom_range(0, 7) == 0) vol = 2'($urandom_range(0, 3));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
